// File: rtl/sphere_scan.sv
// sphere_scan: closest-hit sequencer placed in front of intersect_sphere.
//
// Accepts one primary ray, walks a sphere table held in a synchronous-read
// RAM, starts the intersector once per sphere and keeps the nearest
// non-negative hit distance. One hit record per ray goes out on a
// valid/ready handshake. All vectors and distances are signed 16.16 fixed
// point, 32 bits wide.
//
// Handshakes (ray_* and hit_*): a transfer happens on a rising clock edge
// where valid and ready are both high. valid and the data it qualifies are
// held until that transfer. ray_ready is high only in IDLE, so no second ray
// is buffered. hit_valid stays high, with the record held, until hit_ready.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   ray_valid / ray_ready            ray handshake
//   ray_orig_x/y/z, ray_dir_x/y/z    ray, captured on transfer
//   num_spheres                      table entries to scan, captured on transfer
//   sph_addr                         table read address
//   sph_radius_sqr, sph_center_x/y/z table data, one cycle after sph_addr
//   isect_start                      one-cycle start pulse to the intersector
//   isect_*                          registered intersector operands
//   isect_finish, isect_result,
//   isect_t0, isect_t1               intersector results
//   hit_valid / hit_ready            result handshake
//   hit, hit_idx, hit_t              nearest-hit record
//   timeout_err                      sticky per-ray WAIT watchdog flag
//   dbg_state                        current FSM state
//
// Build option
//   SPHERE_SCAN_TIMEOUT_EN: when defined, a sphere whose WAIT phase lasts
//   63 cycles counts as a miss and timeout_err is set until the next ray is
//   accepted. When undefined, WAIT blocks until finish and timeout_err is 0.
module sphere_scan #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  logic [31:0]      ray_orig_x,
  input  logic [31:0]      ray_orig_y,
  input  logic [31:0]      ray_orig_z,
  input  logic [31:0]      ray_dir_x,
  input  logic [31:0]      ray_dir_y,
  input  logic [31:0]      ray_dir_z,
  input  logic [IDX_W:0]   num_spheres,
  output logic [IDX_W-1:0] sph_addr,
  input  logic [31:0]      sph_radius_sqr,
  input  logic [31:0]      sph_center_x,
  input  logic [31:0]      sph_center_y,
  input  logic [31:0]      sph_center_z,
  output logic             isect_start,
  output logic [31:0]      isect_radius_sqr,
  output logic [31:0]      isect_center_x,
  output logic [31:0]      isect_center_y,
  output logic [31:0]      isect_center_z,
  output logic [31:0]      isect_orig_x,
  output logic [31:0]      isect_orig_y,
  output logic [31:0]      isect_orig_z,
  output logic [31:0]      isect_dir_x,
  output logic [31:0]      isect_dir_y,
  output logic [31:0]      isect_dir_z,
  input  logic             isect_finish,
  input  logic             isect_result,
  input  logic [31:0]      isect_t0,
  input  logic [31:0]      isect_t1,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [31:0]      hit_t,
  output logic             timeout_err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_EVAL  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [31:0] BEST_INIT = 32'h7FFF_FFFF;

  state_t           state_q, state_d;
  logic             ray_ready_q;
  logic             hit_valid_q;
  logic             isect_start_q;
  logic             first_wait_q;
  logic [IDX_W:0]   idx_q;
  logic [IDX_W:0]   num_q;
  logic [IDX_W:0]   idx_inc;
  logic [31:0]      best_t_q;
  logic             hit_q;
  logic [IDX_W-1:0] hit_idx_q;

  logic [31:0] op_radius_sqr_q, op_center_x_q, op_center_y_q, op_center_z_q;
  logic [31:0] op_orig_x_q, op_orig_y_q, op_orig_z_q;
  logic [31:0] op_dir_x_q, op_dir_y_q, op_dir_z_q;

  logic        accept;
  logic        finish_ok;
  logic        wait_expire;
  logic        eval_miss;
  logic        cand_ok;
  logic [31:0] cand_t;
  logic        better;

  // ready_q is required as well as IDLE: in the cycle right after reset
  // release the state is IDLE but the ray port is not yet open.
  assign accept  = (state_q == S_IDLE) && ray_ready_q && ray_valid;
  assign idx_inc = idx_q + {{IDX_W{1'b0}}, 1'b1};

  // The intersector clears finish only on the edge that follows start, so
  // in the first WAIT cycle finish may still belong to the previous sphere.
  assign finish_ok = !first_wait_q && isect_finish;

  // Candidate distance: the nearest non-negative root reported for this sphere.
  always_comb begin
    cand_ok = 1'b0;
    cand_t  = '0;
    if (isect_result && !eval_miss) begin
      if (!isect_t0[31]) begin
        cand_ok = 1'b1;
        cand_t  = isect_t0;
      end else if (!isect_t1[31]) begin
        cand_ok = 1'b1;
        cand_t  = isect_t1;
      end
    end
  end

  // Strict compare: on a tie the earlier (lower) index is kept.
  assign better = cand_ok && ($signed(cand_t) < $signed(best_t_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (num_spheres == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (finish_ok || wait_expire) state_d = S_EVAL;
      S_EVAL:  state_d = (idx_inc == num_q) ? S_DONE : S_FETCH;
      S_DONE:  if (hit_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      ray_ready_q     <= 1'b0;
      hit_valid_q     <= 1'b0;
      isect_start_q   <= 1'b0;
      first_wait_q    <= 1'b0;
      idx_q           <= '0;
      num_q           <= '0;
      best_t_q        <= BEST_INIT;
      hit_q           <= 1'b0;
      hit_idx_q       <= '0;
      op_radius_sqr_q <= '0;
      op_center_x_q   <= '0;
      op_center_y_q   <= '0;
      op_center_z_q   <= '0;
      op_orig_x_q     <= '0;
      op_orig_y_q     <= '0;
      op_orig_z_q     <= '0;
      op_dir_x_q      <= '0;
      op_dir_y_q      <= '0;
      op_dir_z_q      <= '0;
    end else begin
      state_q       <= state_d;
      // Handshake and pulse outputs are decoded from the next state so they
      // come straight out of flops and line up with the state they describe.
      ray_ready_q   <= (state_d == S_IDLE);
      hit_valid_q   <= (state_d == S_DONE);
      isect_start_q <= (state_d == S_START);
      first_wait_q  <= (state_q == S_START);

      if (accept) begin
        op_orig_x_q <= ray_orig_x;
        op_orig_y_q <= ray_orig_y;
        op_orig_z_q <= ray_orig_z;
        op_dir_x_q  <= ray_dir_x;
        op_dir_y_q  <= ray_dir_y;
        op_dir_z_q  <= ray_dir_z;
        num_q       <= num_spheres;
        idx_q       <= '0;
        best_t_q    <= BEST_INIT;
        hit_q       <= 1'b0;
        hit_idx_q   <= '0;
      end

      // Table data for idx_q is on the RAM outputs during LOAD.
      if (state_q == S_LOAD) begin
        op_radius_sqr_q <= sph_radius_sqr;
        op_center_x_q   <= sph_center_x;
        op_center_y_q   <= sph_center_y;
        op_center_z_q   <= sph_center_z;
      end

      if (state_q == S_EVAL) begin
        idx_q <= idx_inc;
        if (better) begin
          best_t_q  <= cand_t;
          hit_idx_q <= idx_q[IDX_W-1:0];
          hit_q     <= 1'b1;
        end
      end
    end
  end

`ifdef SPHERE_SCAN_TIMEOUT_EN
  logic [5:0] wait_cnt_q;
  logic       to_q;
  logic       timeout_err_q;

  // wait_cnt_q is 0 in the first WAIT cycle, so 62 marks the 63rd cycle.
  assign wait_expire = (state_q == S_WAIT) && (wait_cnt_q == 6'd62) && !finish_ok;
  assign eval_miss   = to_q;
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      to_q          <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == S_START) begin
        wait_cnt_q <= '0;
        to_q       <= 1'b0;
      end else if (state_q == S_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 6'd1;
      end
      if (wait_expire) begin
        to_q          <= 1'b1;
        timeout_err_q <= 1'b1;
      end
      if (accept) timeout_err_q <= 1'b0;
    end
  end
`else
  assign wait_expire = 1'b0;
  assign eval_miss   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign ray_ready        = ray_ready_q;
  assign hit_valid        = hit_valid_q;
  assign isect_start      = isect_start_q;
  assign sph_addr         = idx_q[IDX_W-1:0];
  assign hit              = hit_q;
  assign hit_idx          = hit_idx_q;
  assign hit_t            = hit_q ? best_t_q : 32'd0;
  assign isect_radius_sqr = op_radius_sqr_q;
  assign isect_center_x   = op_center_x_q;
  assign isect_center_y   = op_center_y_q;
  assign isect_center_z   = op_center_z_q;
  assign isect_orig_x     = op_orig_x_q;
  assign isect_orig_y     = op_orig_y_q;
  assign isect_orig_z     = op_orig_z_q;
  assign isect_dir_x      = op_dir_x_q;
  assign isect_dir_y      = op_dir_y_q;
  assign isect_dir_z      = op_dir_z_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sphere_scan.sv
// Bench for sphere_scan: a sphere RAM model, an intersector model that
// answers from a per-sphere response table, and a nearest-hit reference
// computed directly from the table contents.
module tb_sphere_scan;
  localparam int IDX_W = 4;
  localparam int NTAB  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // ---------------- DUT signals ----------------
  logic             ray_valid = 1'b0;
  logic             ray_ready;
  logic [31:0]      ray_orig_x = '0, ray_orig_y = '0, ray_orig_z = '0;
  logic [31:0]      ray_dir_x = '0, ray_dir_y = '0, ray_dir_z = '0;
  logic [IDX_W:0]   num_spheres = '0;
  logic [IDX_W-1:0] sph_addr;
  logic [31:0]      sph_radius_sqr = '0, sph_center_x = '0, sph_center_y = '0, sph_center_z = '0;
  logic             isect_start;
  logic [31:0]      isect_radius_sqr, isect_center_x, isect_center_y, isect_center_z;
  logic [31:0]      isect_orig_x, isect_orig_y, isect_orig_z;
  logic [31:0]      isect_dir_x, isect_dir_y, isect_dir_z;
  logic             isect_finish = 1'b0;
  logic             isect_result = 1'b0;
  logic [31:0]      isect_t0 = '0, isect_t1 = '0;
  logic             hit_valid;
  logic             hit_ready = 1'b0;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [31:0]      hit_t;
  logic             timeout_err;
  logic [2:0]       dbg_state;

  sphere_scan #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_orig_x(ray_orig_x), .ray_orig_y(ray_orig_y), .ray_orig_z(ray_orig_z),
    .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
    .num_spheres(num_spheres), .sph_addr(sph_addr),
    .sph_radius_sqr(sph_radius_sqr), .sph_center_x(sph_center_x),
    .sph_center_y(sph_center_y), .sph_center_z(sph_center_z),
    .isect_start(isect_start), .isect_radius_sqr(isect_radius_sqr),
    .isect_center_x(isect_center_x), .isect_center_y(isect_center_y),
    .isect_center_z(isect_center_z), .isect_orig_x(isect_orig_x),
    .isect_orig_y(isect_orig_y), .isect_orig_z(isect_orig_z),
    .isect_dir_x(isect_dir_x), .isect_dir_y(isect_dir_y), .isect_dir_z(isect_dir_z),
    .isect_finish(isect_finish), .isect_result(isect_result),
    .isect_t0(isect_t0), .isect_t1(isect_t1),
    .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit(hit), .hit_idx(hit_idx), .hit_t(hit_t),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- tables ----------------
  logic [31:0] tbl_r[NTAB], tbl_x[NTAB], tbl_y[NTAB], tbl_z[NTAB];
  logic        r_res[NTAB];
  logic [31:0] r_t0[NTAB], r_t1[NTAB];
  int          r_lat[NTAB];   // WAIT length; 0 means the intersector never finishes
  logic [31:0] cur_ox, cur_oy, cur_oz, cur_dx, cur_dy, cur_dz;

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [36:0] exp_q[$];   // {hit, hit_idx[3:0], hit_t[31:0]}
  int start_total = 0;     // written only by the intersector model
  int start_base  = 0;     // written only by the main process

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Sphere RAM: registered read.
  always @(posedge clk) begin
    sph_radius_sqr <= tbl_r[sph_addr];
    sph_center_x   <= tbl_x[sph_addr];
    sph_center_y   <= tbl_y[sph_addr];
    sph_center_z   <= tbl_z[sph_addr];
  end

  // Intersector model. It keeps finish and results from the previous sphere
  // through the cycle after start, then drops finish until its latency runs out.
  int m_cnt = 0;
  int m_k   = 0;
  bit m_act = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
      isect_finish = 1'b0;
    end else if (isect_start) begin
      m_k = (start_total - start_base) % NTAB;
      check("op_radius", isect_radius_sqr, tbl_r[m_k]);
      check("op_cx", isect_center_x, tbl_x[m_k]);
      check("op_cy", isect_center_y, tbl_y[m_k]);
      check("op_cz", isect_center_z, tbl_z[m_k]);
      check("op_orig", {isect_orig_x, isect_orig_y}, {cur_ox, cur_oy});
      check("op_dir", {isect_orig_z, isect_dir_x}, {cur_oz, cur_dx});
      check("op_dir_yz", {isect_dir_y, isect_dir_z}, {cur_dy, cur_dz});
      start_total++;
      m_act = 1'b1;
      m_cnt = 0;
    end else if (m_act) begin
      m_cnt++;
      if (m_cnt >= 2) begin
        if (r_lat[m_k] != 0 && m_cnt >= r_lat[m_k]) begin
          isect_finish = 1'b1;
          isect_result = r_res[m_k];
          isect_t0     = r_t0[m_k];
          isect_t1     = r_t1[m_k];
          m_act        = 1'b0;
        end else begin
          isect_finish = 1'b0;
        end
      end
    end
  end

  // Reference: nearest non-negative root over the first n spheres, earliest
  // index wins a tie, timed-out spheres count as misses.
  function automatic logic [36:0] ref_hit(input int n);
    int   best = 32'h7FFF_FFFF;
    int   bidx = 0;
    bit   found = 1'b0;
    int   c;
    bit   has;
    for (int k = 0; k < n; k++) begin
      has = 1'b0;
      c   = 0;
      if (r_lat[k] != 0 && r_res[k]) begin
        if ($signed(r_t0[k]) >= 0) begin c = r_t0[k]; has = 1'b1; end
        else if ($signed(r_t1[k]) >= 0) begin c = r_t1[k]; has = 1'b1; end
      end
      if (has && c < best) begin best = c; bidx = k; found = 1'b1; end
    end
    if (!found) return 37'd0;
    return {1'b1, 4'(bidx), 32'(best)};
  endfunction

  function automatic logic [31:0] rand_pos();
    return $urandom_range(0, 32'h00FF_0000);
  endfunction
  function automatic logic [31:0] rand_neg();
    return 32'd0 - (32'd1 + $urandom_range(0, 32'h00FF_FFFF));
  endfunction

  task automatic fill_rand(input int n);
    int kind;
    for (int k = 0; k < n; k++) begin
      tbl_r[k] = $urandom; tbl_x[k] = $urandom; tbl_y[k] = $urandom; tbl_z[k] = $urandom;
      r_lat[k] = $urandom_range(2, 5);
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin r_res[k] = 1'b0; r_t0[k] = rand_pos(); r_t1[k] = rand_pos(); end
        1: begin r_res[k] = 1'b1; r_t0[k] = rand_pos(); r_t1[k] = rand_pos(); end
        2: begin r_res[k] = 1'b1; r_t0[k] = rand_neg(); r_t1[k] = rand_pos(); end
        3: begin r_res[k] = 1'b1; r_t0[k] = rand_neg(); r_t1[k] = rand_neg(); end
        default: begin r_res[k] = 1'b1; r_t0[k] = 32'h0004_0000; r_t1[k] = rand_pos(); end
      endcase
    end
  endtask

  // Directed entry: result r, roots t0/t1, table data random.
  task automatic set_sph(input int k, input logic r, input logic [31:0] t0,
                         input logic [31:0] t1, input int lat);
    tbl_r[k] = $urandom; tbl_x[k] = $urandom; tbl_y[k] = $urandom; tbl_z[k] = $urandom;
    r_res[k] = r; r_t0[k] = t0; r_t1[k] = t1; r_lat[k] = lat;
  endtask

  task automatic drive_ray(input int n);
    cur_ox = $urandom; cur_oy = $urandom; cur_oz = $urandom;
    cur_dx = $urandom; cur_dy = $urandom; cur_dz = $urandom;
    ray_orig_x = cur_ox; ray_orig_y = cur_oy; ray_orig_z = cur_oz;
    ray_dir_x  = cur_dx; ray_dir_y  = cur_dy; ray_dir_z  = cur_dz;
    num_spheres = (IDX_W+1)'(n);
    ray_valid = 1'b1;
  endtask

  // One full ray: transfer, latency, record, optional back-pressure, release.
  task automatic run_ray(input string tag, input int n, input int hold);
    int exp_lat = 1;
    int cyc;
    logic [36:0] e;
    logic exp_tmo = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_lat += 4 + ((r_lat[k] == 0) ? 63 : r_lat[k]);
`ifdef SPHERE_SCAN_TIMEOUT_EN
      if (r_lat[k] == 0) exp_tmo = 1'b1;
`endif
    end
    exp_q.push_back(ref_hit(n));
    start_base = start_total;
    check({tag, "_ready_idle"}, ray_ready, 1'b1);
    drive_ray(n);
    @(negedge clk);
    ray_valid = 1'b0;
    cyc = 1;
    while (!hit_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_hit"}, hit, e[36]);
    check({tag, "_hit_idx"}, hit_idx, e[35:32]);
    check({tag, "_hit_t"}, hit_t, e[31:0]);
    check({tag, "_starts"}, start_total - start_base, n);
    check({tag, "_ready_busy"}, ray_ready, 1'b0);
    check({tag, "_timeout_err"}, timeout_err, exp_tmo);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, hit_valid, 1'b1);
      check({tag, "_hold_rec"}, {hit, hit_idx, hit_t}, e);
      check({tag, "_hold_ready"}, ray_ready, 1'b0);
    end
    hit_ready = 1'b1;
    @(negedge clk);
    hit_ready = 1'b0;
    check({tag, "_valid_drop"}, hit_valid, 1'b0);
    check({tag, "_ready_back"}, ray_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hit_valid"}, hit_valid, 1'b0);
    check({tag, "_ray_ready"}, ray_ready, 1'b0);
    check({tag, "_isect_start"}, isect_start, 1'b0);
    check({tag, "_rec"}, {hit, hit_idx, hit_t}, 37'd0);
    check({tag, "_sph_addr"}, sph_addr, '0);
    check({tag, "_ops_a"}, {isect_radius_sqr, isect_center_x, isect_center_y}, 96'd0);
    check({tag, "_ops_b"}, {isect_center_z, isect_orig_x, isect_orig_y}, 96'd0);
    check({tag, "_ops_c"}, {isect_orig_z, isect_dir_x, isect_dir_y, isect_dir_z}, 128'd0);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    for (int k = 0; k < NTAB; k++) set_sph(k, 1'b0, 32'd0, 32'd0, 2);

    // Reset behaviour.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_ready", ray_ready, 1'b1);

    // Empty scan.
    run_ray("n0", 0, 0);

    // Three spheres, middle one nearest.
    set_sph(0, 1'b1, 32'h0005_0000, 32'h0006_0000, 2);
    set_sph(1, 1'b1, 32'h0002_0000, 32'h0003_0000, 3);
    set_sph(2, 1'b1, 32'h0009_0000, 32'h000A_0000, 4);
    run_ray("three", 3, 0);

    // Origin inside a sphere: far root used.
    set_sph(0, 1'b1, 32'hFFFF_0000, 32'h0003_0000, 2);
    run_ray("inside", 1, 0);

    // Both roots behind the origin.
    set_sph(0, 1'b1, 32'hFFFF_0000, 32'hFFFE_0000, 2);
    run_ray("behind", 1, 0);

    // Equal distance on indices 2 and 5, with back-pressure.
    for (int k = 0; k < 6; k++) set_sph(k, 1'b0, 32'h0001_0000, 32'h0001_0000, 2);
    set_sph(2, 1'b1, 32'h0004_0000, 32'h0008_0000, 2);
    set_sph(5, 1'b1, 32'h0004_0000, 32'h0008_0000, 3);
    run_ray("tie", 6, 10);

    // Reset in the WAIT phase of sphere 1, then a fresh ray from index 0.
    for (int k = 0; k < 3; k++) set_sph(k, 1'b1, 32'h0001_0000, 32'h0002_0000, 5);
    start_base = start_total;
    drive_ray(3);
    @(negedge clk);
    ray_valid = 1'b0;
    cyc = 0;
    while ((start_total - start_base) < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_sph1", (start_total - start_base) >= 2, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready", ray_ready, 1'b1);
    fill_rand(2);
    run_ray("after_reset", 2, 1);

`ifdef SPHERE_SCAN_TIMEOUT_EN
    set_sph(0, 1'b1, 32'h0001_0000, 32'h0002_0000, 0);
    set_sph(1, 1'b1, 32'h0003_0000, 32'h0004_0000, 2);
    run_ray("timeout", 2, 0);
    fill_rand(1);
    run_ray("timeout_clear", 1, 0);
`endif

    // Full table.
    fill_rand(NTAB);
    run_ray("full", NTAB, 0);

    // Random rays.
    for (int i = 0; i < 20; i++) begin
      int n;
      n = $urandom_range(0, 7);
      fill_rand(n);
      run_ray($sformatf("rand%0d", i), n, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
